baccarat_datapath: RTL and testbench

Card datapath for the Baccarat table. It deals pseudo-random card values and latches them into six hand slots when the Baccarat state machine pulses its `load_*` strobes. It computes the player and dealer scores combinationally from the latched cards and returns `pscore`, `dscore` and `pcard3` to the state machine. The block sits directly downstream of the state machine's load outputs and directly upstream of its score inputs and the HEX display decoders.

---
 rtl/baccarat_pkg.sv | 29 ++
 rtl/baccarat_datapath_card_dealer.sv | 34 +++
 rtl/baccarat_datapath.sv | 91 +++++++++
 tb/tb_baccarat_datapath.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared Baccarat types and scoring helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
// Imported by the datapath, the table state machine and the HEX decoders.
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_MAX   = 4'd13;

    // A..9 count their pip value; empty slot, 10, J, Q, K count zero.
    function automatic logic [3:0] face_value(input card_t c);
        return (c != CARD_EMPTY && c <= 4'd9) ? c : 4'd0;
    endfunction

    // Three face values sum to at most 27, so two conditional subtractions
    // are enough to reduce mod 10 without a divider.
    function automatic logic [3:0] hand_score(input card_t c1, input card_t c2, input card_t c3);
        logic [4:0] sum;
        sum = {1'b0, face_value(c1)} + {1'b0, face_value(c2)} + {1'b0, face_value(c3)};
        if (sum >= 5'd20)
            sum = sum - 5'd20;
        else if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

endpackage

// File: rtl/baccarat_datapath_card_dealer.sv
// Free-running mod-13 card counter, 1..13, advancing by STEP every cycle.
// Latency: new value one cycle after each rising edge; SEED one edge after reset.
// Backpressure: none, the counter never stalls.
// Ports: slow_clock (clock), reset (sync, active-high), deal_card (current card 1..13).
module card_dealer
    import baccarat_pkg::*;
#(
    parameter card_t SEED = 4'd1,
    parameter card_t STEP = 4'd1
) (
    input  logic  slow_clock,
    input  logic  reset,
    output card_t deal_card
);

    card_t      r_deal;
    logic [4:0] w_sum;
    card_t      w_next;

    // Work in the 0..12 domain: (deal-1)+STEP is at most 24, so one
    // conditional subtraction of 13 gives the modulus.
    assign w_sum  = {1'b0, r_deal} - 5'd1 + {1'b0, STEP};
    assign w_next = (w_sum >= 5'd13) ? card_t'(w_sum - 5'd12) : card_t'(w_sum + 5'd1);

    always_ff @(posedge slow_clock) begin
        if (reset)
            r_deal <= SEED;
        else
            r_deal <= w_next;
    end

    assign deal_card = r_deal;

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: deals cards into six hand slots and scores both hands.
// Latency: slot updates on the strobe edge; scores follow slots combinationally.
// Backpressure: none; every load strobe is accepted, misuse only raises load_error.
// Ports: slow_clock/reset (sync, active-high); load_{p,d}card{1,2,3} strobes;
//        {p,d}card{1,2,3} slot values; pscore/dscore 0..9; deal_card 1..13;
//        load_error sticky until reset.
module baccarat_datapath
    import baccarat_pkg::*;
#(
    parameter card_t SEED = 4'd1,
    parameter card_t STEP = 4'd1
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] deal_card,
    output logic       load_error
);

    // Slot order: 0..2 player cards 1..3, 3..5 dealer cards 1..3.
    logic [5:0] w_ld;
    card_t      w_deal;
    card_t      r_slot [6];
    logic       r_load_error;
    logic       w_multi;
    logic       w_hit_full;

    assign w_ld = {load_dcard3, load_dcard2, load_dcard1,
                   load_pcard3, load_pcard2, load_pcard1};

    card_dealer #(
        .SEED (SEED),
        .STEP (STEP)
    ) u_card_dealer (
        .slow_clock (slow_clock),
        .reset      (reset),
        .deal_card  (w_deal)
    );

    // Clearing the lowest set bit leaves something only if two or more strobes are high.
    assign w_multi = (w_ld & (w_ld - 6'd1)) != 6'd0;

    always_comb begin
        w_hit_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (w_ld[i] && r_slot[i] != CARD_EMPTY)
                w_hit_full = 1'b1;
        end
    end

    // Violations are flagged but never blocked: every strobed slot still loads.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            for (int i = 0; i < 6; i++)
                r_slot[i] <= CARD_EMPTY;
            r_load_error <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_ld[i])
                    r_slot[i] <= w_deal;
            end
            if (w_multi || w_hit_full)
                r_load_error <= 1'b1;
        end
    end

    assign pcard1     = r_slot[0];
    assign pcard2     = r_slot[1];
    assign pcard3     = r_slot[2];
    assign dcard1     = r_slot[3];
    assign dcard2     = r_slot[4];
    assign dcard3     = r_slot[5];
    assign pscore     = hand_score(r_slot[0], r_slot[1], r_slot[2]);
    assign dscore     = hand_score(r_slot[3], r_slot[4], r_slot[5]);
    assign deal_card  = w_deal;
    assign load_error = r_load_error;

endmodule

// File: tb/tb_baccarat_datapath.sv
module tb_baccarat_datapath;

    typedef struct packed {
        logic [3:0] dc;
        logic [3:0] p1, p2, p3;
        logic [3:0] d1, d2, d3;
        logic [3:0] ps, ds;
        logic       err;
    } snap_t;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] P1   = 6'b000001;
    localparam logic [5:0] P2   = 6'b000010;
    localparam logic [5:0] P3   = 6'b000100;
    localparam logic [5:0] D1   = 6'b001000;
    localparam logic [5:0] D2   = 6'b010000;
    localparam logic [5:0] D3   = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] ld  = 6'd0;

    always #5 clk = ~clk;

    // Instance A: SEED=1, never strobed (counter wrap). Instance B: SEED=9.
    logic [3:0] a_p1, a_p2, a_p3, a_d1, a_d2, a_d3, a_ps, a_ds, a_dc;
    logic       a_err;
    logic [3:0] b_p1, b_p2, b_p3, b_d1, b_d2, b_d3, b_ps, b_ds, b_dc;
    logic       b_err;

    baccarat_datapath #(.SEED(4'd1), .STEP(4'd1)) u_dut_a (
        .slow_clock (clk),      .reset (rst),
        .load_pcard1(1'b0),     .load_pcard2(1'b0),     .load_pcard3(1'b0),
        .load_dcard1(1'b0),     .load_dcard2(1'b0),     .load_dcard3(1'b0),
        .pcard1(a_p1), .pcard2(a_p2), .pcard3(a_p3),
        .dcard1(a_d1), .dcard2(a_d2), .dcard3(a_d3),
        .pscore(a_ps), .dscore(a_ds), .deal_card(a_dc), .load_error(a_err)
    );

    baccarat_datapath #(.SEED(4'd9), .STEP(4'd1)) u_dut_b (
        .slow_clock (clk),      .reset (rst),
        .load_pcard1(ld[0]),    .load_pcard2(ld[1]),    .load_pcard3(ld[2]),
        .load_dcard1(ld[3]),    .load_dcard2(ld[4]),    .load_dcard3(ld[5]),
        .pcard1(b_p1), .pcard2(b_p2), .pcard3(b_p3),
        .dcard1(b_d1), .dcard2(b_d2), .dcard3(b_d3),
        .pscore(b_ps), .dscore(b_ds), .deal_card(b_dc), .load_error(b_err)
    );

    snap_t snap_a, snap_b;
    assign snap_a = '{a_dc, a_p1, a_p2, a_p3, a_d1, a_d2, a_d3, a_ps, a_ds, a_err};
    assign snap_b = '{b_dc, b_p1, b_p2, b_p3, b_d1, b_d2, b_d3, b_ps, b_ds, b_err};

    // Scoreboard
    int    cyc_cnt = 0;
    int    checks  = 0;
    int    errors  = 0;
    int    q_cyc[$];
    int    q_who[$];
    snap_t q_exp[$];
    string q_name[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic snap_t mk(input int dc, input int p1, input int p2, input int p3,
                                 input int d1, input int d2, input int d3,
                                 input int ps, input int ds, input int err);
        snap_t s;
        s.dc = 4'(dc); s.p1 = 4'(p1); s.p2 = 4'(p2); s.p3 = 4'(p3);
        s.d1 = 4'(d1); s.d2 = 4'(d2); s.d3 = 4'(d3);
        s.ps = 4'(ps); s.ds = 4'(ds); s.err = 1'(err);
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("deal=%0d p=%0d/%0d/%0d d=%0d/%0d/%0d ps=%0d ds=%0d err=%0d",
                         s.dc, s.p1, s.p2, s.p3, s.d1, s.d2, s.d3, s.ps, s.ds, s.err);
    endfunction

    // Monitor: outputs are presented once per rising edge; compare at the
    // following falling edge every expectation targeted at this cycle.
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc_cnt) begin
            int    tcyc;
            int    who;
            snap_t e;
            snap_t got;
            string nm;
            tcyc = q_cyc.pop_front();
            who  = q_who.pop_front();
            e    = q_exp.pop_front();
            nm   = q_name.pop_front();
            got  = (who == 0) ? snap_a : snap_b;
            checks++;
            if (tcyc != cyc_cnt) begin
                errors++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", nm, tcyc, cyc_cnt);
            end else if (got !== e) begin
                errors++;
                $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(e));
            end
        end
    end

    // Drive inputs half a cycle before the edge that samples them.
    task automatic tick(input logic [5:0] ld_i, input logic rst_i);
        @(negedge clk);
        ld  = ld_i;
        rst = rst_i;
    endtask

    // Expected state after the edge following the latest tick.
    task automatic expect_dut(input int who, input string nm, input snap_t s);
        q_cyc.push_back(cyc_cnt + 1);
        q_who.push_back(who);
        q_exp.push_back(s);
        q_name.push_back(nm);
    endtask

    int wrap_v[15]  = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 1, 2, 3};
    int idle_v[10]  = '{6, 7, 8, 9, 10, 11, 12, 13, 1, 2};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state of both instances
        tick(NONE, 1'b1);
        tick(NONE, 1'b1);
        expect_dut(0, "reset_a", mk(1, 0,0,0, 0,0,0, 0,0, 0));
        expect_dut(1, "reset_b", mk(9, 0,0,0, 0,0,0, 0,0, 0));

        // Counter wrap on instance A: 1,2,..,13,1,2,3
        for (int k = 0; k < 15; k++) begin
            tick(NONE, 1'b0);
            expect_dut(0, $sformatf("wrap_%0d", k), mk(wrap_v[k], 0,0,0, 0,0,0, 0,0, 0));
        end

        // Basic hand: 9 then 1 -> score 0
        tick(NONE, 1'b1);
        expect_dut(1, "basic_reset", mk(9, 0,0,0, 0,0,0, 0,0, 0));
        tick(P1, 1'b0);
        expect_dut(1, "basic_p1", mk(10, 9,0,0, 0,0,0, 9,0, 0));
        for (int k = 0; k < 4; k++) tick(NONE, 1'b0);
        expect_dut(1, "basic_idle", mk(1, 9,0,0, 0,0,0, 9,0, 0));
        tick(P2, 1'b0);
        expect_dut(1, "basic_p2", mk(2, 9,1,0, 0,0,0, 0,0, 0));

        // Face cards: dealer 10,K,7 -> 7; player 8,9,6 -> 3
        tick(NONE, 1'b1);
        expect_dut(1, "face_reset", mk(9, 0,0,0, 0,0,0, 0,0, 0));
        tick(P2, 1'b0);
        expect_dut(1, "face_p2", mk(10, 0,9,0, 0,0,0, 9,0, 0));
        tick(D1, 1'b0);
        expect_dut(1, "face_d1", mk(11, 0,9,0, 10,0,0, 9,0, 0));
        tick(NONE, 1'b0);
        tick(NONE, 1'b0);
        tick(D2, 1'b0);
        expect_dut(1, "face_d2", mk(1, 0,9,0, 10,13,0, 9,0, 0));
        for (int k = 0; k < 5; k++) tick(NONE, 1'b0);
        tick(P3, 1'b0);
        expect_dut(1, "face_p3", mk(7, 0,9,6, 10,13,0, 5,0, 0));
        tick(D3, 1'b0);
        expect_dut(1, "face_d3", mk(8, 0,9,6, 10,13,7, 5,7, 0));
        tick(P1, 1'b0);
        expect_dut(1, "face_p1", mk(9, 8,9,6, 10,13,7, 3,7, 0));

        // Simultaneous strobes at deal_card = 4
        tick(NONE, 1'b1);
        for (int k = 0; k < 8; k++) tick(NONE, 1'b0);
        tick(P1 | D1, 1'b0);
        expect_dut(1, "simul_load", mk(5, 4,0,0, 4,0,0, 4,4, 1));
        for (int k = 0; k < 10; k++) begin
            tick(NONE, 1'b0);
            expect_dut(1, $sformatf("simul_hold_%0d", k), mk(idle_v[k], 4,0,0, 4,0,0, 4,4, 1));
        end

        // Reload of dealer slot 2, three cycles apart
        tick(NONE, 1'b1);
        expect_dut(1, "reload_reset", mk(9, 0,0,0, 0,0,0, 0,0, 0));
        tick(D2, 1'b0);
        expect_dut(1, "reload_first", mk(10, 0,0,0, 0,9,0, 0,9, 0));
        tick(NONE, 1'b0);
        tick(NONE, 1'b0);
        tick(D2, 1'b0);
        expect_dut(1, "reload_second", mk(13, 0,0,0, 0,12,0, 0,0, 1));

        // Reset mid-hand wins over load_pcard3; error from previous step clears
        tick(NONE, 1'b1);
        expect_dut(1, "mid_reset_clear", mk(9, 0,0,0, 0,0,0, 0,0, 0));
        tick(P1, 1'b0);
        tick(D1, 1'b0);
        tick(P2, 1'b0);
        tick(D2, 1'b0);
        expect_dut(1, "mid_four_cards", mk(13, 9,11,0, 10,12,0, 9,0, 0));
        tick(P3, 1'b1);
        expect_dut(1, "mid_reset", mk(9, 0,0,0, 0,0,0, 0,0, 0));
        tick(NONE, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && q_exp.size() > 0; k++) @(negedge clk);
        #1;
        if (q_exp.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never compared, required 0", q_exp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
